// File: rtl/leading_zero_denormalizer_32.sv
// leading_zero_denormalizer_32: iterative right shift by a 5-bit leading-zero count, one count bit per cycle, with sticky
// Ports:
//   i_CLK, i_RESET               clock, synchronous active-high reset
//   i_VALID/o_READY              request handshake carrying i_WORD, i_ZERO_COUNT, i_ALL_ZEROS
//   o_VALID/i_READY              result handshake carrying o_WORD, o_STICKY, o_ALL_ZEROS
module leading_zero_denormalizer_32 (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [31:0] i_WORD,
  input  logic [4:0]  i_ZERO_COUNT,
  input  logic        i_ALL_ZEROS,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic [31:0] o_WORD,
  output logic        o_STICKY,
  output logic        o_ALL_ZEROS
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic        zeros_q, zeros_d;
  logic [5:0]  amt;
  logic [31:0] mask;
  assign amt  = 6'd1 << stage_q;
  // bits that fall off the bottom when shifting by this stage's weight
  assign mask = (32'd1 << amt) - 32'd1;
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    zeros_d  = zeros_q;
    case (state_q)
      IDLE: if (i_VALID) begin
        word_d   = i_ALL_ZEROS ? 32'd0 : i_WORD;
        cnt_d    = i_ZERO_COUNT;
        zeros_d  = i_ALL_ZEROS;
        sticky_d = 1'b0;
        stage_d  = 3'd4;
        state_d  = i_ALL_ZEROS ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_q[stage_q]) begin
          word_d   = word_q >> amt;
          sticky_d = sticky_q | (|(word_q & mask));
        end
        stage_d = stage_q - 3'd1;
        state_d = (stage_q == 3'd0) ? DONE : SHIFT;
      end
      DONE:    state_d = i_READY ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q  <= IDLE;
      stage_q  <= 3'd0;
      word_q   <= 32'd0;
      cnt_q    <= 5'd0;
      sticky_q <= 1'b0;
      zeros_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      zeros_q  <= zeros_d;
    end
  end
  assign o_READY     = state_q == IDLE;
  assign o_VALID     = state_q == DONE;
  assign o_WORD      = word_q;
  assign o_STICKY    = sticky_q;
  assign o_ALL_ZEROS = zeros_q;
endmodule

// File: tb/tb_leading_zero_denormalizer_32.sv
// tb_leading_zero_denormalizer_32: directed bench with a reference model and a per-cycle result checker
module tb_leading_zero_denormalizer_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_word;
  logic [4:0]  i_cnt;
  logic        i_az;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_word;
  logic        o_sticky;
  logic        o_az;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_word;
  logic        exp_sticky;
  logic        exp_az;
  int          lat;

  leading_zero_denormalizer_32 dut (
    .i_CLK(clk), .i_RESET(rst), .i_VALID(i_valid), .o_READY(o_ready),
    .i_WORD(i_word), .i_ZERO_COUNT(i_cnt), .i_ALL_ZEROS(i_az),
    .o_VALID(o_valid), .i_READY(i_ready), .o_WORD(o_word),
    .o_STICKY(o_sticky), .o_ALL_ZEROS(o_az)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] w, input logic [4:0] c, input logic z);
    logic [31:0] lost;
    lost = w & ((32'd1 << c) - 32'd1);
    return z ? 33'd0 : {|lost, w >> c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      chk("held_word", o_word, exp_word);
      chk("held_sticky", {31'd0, o_sticky}, {31'd0, exp_sticky});
      chk("held_allzeros", {31'd0, o_az}, {31'd0, exp_az});
      chk("ready_low_in_done", {31'd0, o_ready}, 32'd0);
    end
  end

  // Presents one request, optionally keeps i_VALID up with junk while busy, then waits for o_VALID.
  task automatic start(input logic [31:0] w, input logic [4:0] c, input logic z, input bit junk);
    logic [32:0] m;
    chk("ready_before_req", {31'd0, o_ready}, 32'd1);
    m = model(w, c, z);
    {exp_sticky, exp_word} = m;
    exp_az  = z;
    i_valid = 1'b1;
    i_word  = w;
    i_cnt   = c;
    i_az    = z;
    tick;
    if (junk) begin
      i_word = 32'hDEADBEEF;
      i_cnt  = 5'd3;
      i_az   = 1'b0;
    end else i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick;
      lat++;
    end
    i_valid = 1'b0;
  endtask

  task automatic finish_req;
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("valid_drop", {31'd0, o_valid}, 32'd0);
    chk("ready_rise", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; i_valid = 1'b0; i_word = '0; i_cnt = '0; i_az = 1'b0; i_ready = 1'b0;
    exp_word = '0; exp_sticky = 1'b0; exp_az = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_word", o_word, 32'd0);
    chk("rst_sticky", {31'd0, o_sticky}, 32'd0);
    chk("rst_allzeros", {31'd0, o_az}, 32'd0);

    start(32'h80000000, 5'd31, 1'b0, 1'b0);
    chk("max_lat", lat, 5);
    chk("max_word", o_word, 32'h00000001);
    chk("max_sticky", {31'd0, o_sticky}, 32'd0);
    finish_req;

    start(32'hC0000000, 5'd31, 1'b0, 1'b0);
    chk("maxs_word", o_word, 32'h00000001);
    chk("maxs_sticky", {31'd0, o_sticky}, 32'd1);
    finish_req;

    start(32'hF0000000, 5'd4, 1'b0, 1'b0);
    chk("mid_lat", lat, 5);
    chk("mid_word", o_word, 32'h0F000000);
    chk("mid_sticky", {31'd0, o_sticky}, 32'd0);
    finish_req;

    start(32'h81234567, 5'd0, 1'b0, 1'b0);
    chk("pass_lat", lat, 5);
    chk("pass_word", o_word, 32'h81234567);
    chk("pass_sticky", {31'd0, o_sticky}, 32'd0);
    finish_req;

    start(32'h8000000F, 5'd3, 1'b0, 1'b0);
    chk("low_word", o_word, 32'h10000001);
    chk("low_sticky", {31'd0, o_sticky}, 32'd1);
    finish_req;

    start(32'hFFFFFFFF, 5'd7, 1'b1, 1'b0);
    chk("az_lat", lat, 0);
    chk("az_word", o_word, 32'd0);
    chk("az_sticky", {31'd0, o_sticky}, 32'd0);
    chk("az_flag", {31'd0, o_az}, 32'd1);
    finish_req;

    start(32'hA5A5A5A5, 5'd21, 1'b0, 1'b1);
    chk("busy_word", o_word, 32'h0000052D);
    chk("busy_sticky", {31'd0, o_sticky}, 32'd1);
    held = o_word;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      chk("bp_word", o_word, held);
    end
    finish_req;

    i_ready = 1'b1;
    start(32'h7FFFFFFF, 5'd9, 1'b0, 1'b0);
    tick;
    chk("fast_drain_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b0;

    i_valid = 1'b1; i_word = 32'h80000000; i_cnt = 5'd16; i_az = 1'b0;
    tick;
    i_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_word", o_word, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("midrst_no_valid", {31'd0, o_valid}, 32'd0);
    end

    rst = 1'b1; i_valid = 1'b1; i_word = 32'h12345678; i_cnt = 5'd1;
    tick;
    rst = 1'b0; i_valid = 1'b0;
    tick;
    chk("rst_prio_ready", {31'd0, o_ready}, 32'd1);

    start(32'h80000000, 5'd16, 1'b0, 1'b0);
    chk("fresh_lat", lat, 5);
    chk("fresh_word", o_word, 32'h00008000);
    finish_req;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/leading_zero_denormalizer_32.md
# leading_zero_denormalizer_32

Iterative 32-bit denormalizer that undoes a leading-zero normalization step. It takes a left-justified word and the 5-bit leading-zero count produced by the 32-bit zero counter, and right-shifts the word back by that count. Alongside the shifted word it reports a sticky bit: the OR of every bit shifted out. It sits downstream of the normalize/arithmetic path, for example when restoring a fixed-point result. One count bit is processed per cycle, with valid/ready handshakes on both sides.

## Interface
- No parameters. Width is fixed at 32 bits to match the 32-bit zero counter; count width is 5.
- i_CLK  input  1  clock; all logic on the rising edge.
- i_RESET  input  1  synchronous, active-high reset.
- i_VALID  input  1  input request valid.
- o_READY  output  1  block idle and able to accept a request.
- i_WORD  input  32  normalized word (normally MSB = 1; not required).
- i_ZERO_COUNT  input  5  right-shift amount, 0..31.
- i_ALL_ZEROS  input  1  source word was zero; forces a zero result.
- o_VALID  output  1  result valid.
- i_READY  input  1  downstream accepts the result.
- o_WORD  output  32  denormalized word, i_WORD >> i_ZERO_COUNT.
- o_STICKY  output  1  OR of all bits shifted out.
- o_ALL_ZEROS  output  1  registered copy of i_ALL_ZEROS for the held result.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. A 3-bit stage index selects the count bit.
- **IDLE**
  - o_READY = 1.
  - Acceptance occurs on an edge with i_VALID & o_READY.
  - On acceptance, the block latches the word register ← i_WORD, the count register ← i_ZERO_COUNT and all-zeros ← i_ALL_ZEROS, and clears sticky.
  - If i_ALL_ZEROS: word ← 0, sticky ← 0, next state DONE.
  - Otherwise: stage ← 4, next state SHIFT.
- **SHIFT**, one edge per stage k = 4, 3, 2, 1, 0:
  - If count[k] = 1, the word is right-shifted by 2^k with zero fill, and sticky |= OR of the 2^k LSBs shifted out.
  - If count[k] = 0, word and sticky hold.
  - Stage decrements after each edge. After stage 0, next state is DONE.
  - The full five stages always run, so latency is independent of the count value.
- **DONE**
  - o_VALID = 1. o_WORD, o_STICKY and o_ALL_ZEROS are stable and held.
  - When i_READY = 1 on an edge, the next state is IDLE.
- o_READY is 0 in SHIFT and DONE. Input signals are ignored outside IDLE.
- Arithmetic: the shift is logical (zero fill) and is never arithmetic.
  - Count 0 gives pass-through with sticky 0.
  - Count 31 leaves only the original bit 31 in o_WORD[0]; sticky is the OR of i_WORD[30:0].

## Timing
- Reset values, in the cycle after any edge with i_RESET = 1:
  - state IDLE, o_READY = 1, o_VALID = 0;
  - o_WORD = 0, o_STICKY = 0, o_ALL_ZEROS = 0.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- Normal request: accepted on edge E0; shift stages on E1..E5; o_VALID = 1 from the cycle after E5. Latency is 5 cycles from the acceptance edge.
- All-zeros request: accepted on E0; o_VALID = 1 from the cycle after E0. Latency is 1 cycle.
- Result handshake:
  - The result completes on the first edge in DONE with i_READY = 1. o_READY rises in the following cycle.
  - i_READY already high on DONE entry gives 1 cycle in DONE.
  - Minimum normal throughput is one request per 7 cycles.
- Backpressure: while i_READY = 0, DONE persists indefinitely and outputs do not change.
- Reset mid-operation (during SHIFT or DONE): the next state is IDLE, outputs take reset values, and the in-flight request is discarded with no o_VALID pulse.
- Reset has priority over acceptance: an edge with i_RESET = 1 and i_VALID = 1 does not accept.

## Test plan
- **Max shift, sticky clear:** i_WORD = 0x80000000, count 31 → o_WORD = 0x00000001, o_STICKY = 0, o_VALID 5 cycles after acceptance.
- **Max shift, sticky set:** i_WORD = 0xC0000000, count 31 → o_WORD = 0x00000001, o_STICKY = 1.
- **Mid shift and pass-through:**
  - i_WORD = 0xF0000000, count 4 → o_WORD = 0x0F000000, o_STICKY = 0.
  - i_WORD = 0x81234567, count 0 → o_WORD = 0x81234567, o_STICKY = 0.
  - Both cases have the same 5-cycle latency.
- **All-zeros fast path:** i_ALL_ZEROS = 1, i_WORD = 0xFFFFFFFF → o_WORD = 0, o_STICKY = 0, o_ALL_ZEROS = 1, o_VALID in the cycle after acceptance.
- **Backpressure and busy:**
  - Hold i_READY = 0 for 10 cycles in DONE → o_VALID and o_WORD stay constant; o_READY stays 0.
  - Keep i_VALID asserted with new data during SHIFT → ignored; the result matches the first request only.
- **Reset mid-operation:** assert i_RESET at E3 of a request with i_WORD = 0x80000000, count 16 → IDLE next cycle, o_READY = 1, o_VALID = 0, o_WORD = 0. Then a fresh request with i_WORD = 0x80000000, count 16 → 0x00008000.
